// File: rtl/mc_defs.sv
// Shared definitions for the multi-cycle MIPS control unit: opcode/funct
// constants, ALU and next-PC select encodings, extender modes and the
// 4-bit FSM state encoding.
package mc_defs;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_OR   = 2'b10;

    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_JMP  = 2'b10;

    localparam logic EXT_ZERO = 1'b0;
    localparam logic EXT_SIGN = 1'b1;

    typedef logic [3:0] state_t;

    localparam state_t S_RST     = 4'd0;
    localparam state_t S_FETCH   = 4'd1;
    localparam state_t S_DCD     = 4'd2;
    localparam state_t S_EXE_R   = 4'd3;
    localparam state_t S_WB_R    = 4'd4;
    localparam state_t S_EXE_I   = 4'd5;
    localparam state_t S_WB_I    = 4'd6;
    localparam state_t S_MEM_ADR = 4'd7;
    localparam state_t S_MEM_RD  = 4'd8;
    localparam state_t S_WB_LW   = 4'd9;
    localparam state_t S_MEM_WR  = 4'd10;
    localparam state_t S_BRANCH  = 4'd11;
    localparam state_t S_JUMP    = 4'd12;
    localparam state_t S_HALT    = 4'd13;

endpackage

// File: rtl/mc_ctrl_out.sv
// Combinational state-to-control decoder.
// Ports: state/funct/zero/en in; datapath strobes, mux selects and the
// instrDone pulse out. Strobes are suppressed while en is low; selects
// keep their state-decoded values so the datapath stays quiet but stable.
import mc_defs::*;

module mc_ctrl_out #(
    parameter logic ZERO = 1'b0,
    parameter logic SIGN = 1'b1
) (
    input  state_t     state,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       en,
    output logic       pcWr,
    output logic       irWr,
    output logic       regWr,
    output logic       memWr,
    output logic       extOp,
    output logic       aluSrc,
    output logic [1:0] aluOp,
    output logic       regDst,
    output logic       memToReg,
    output logic [1:0] npcOp,
    output logic       instrDone
);

    logic pc_raw, ir_raw, reg_raw, mem_raw, done_raw;

    always_comb begin
        pc_raw   = 1'b0;
        ir_raw   = 1'b0;
        reg_raw  = 1'b0;
        mem_raw  = 1'b0;
        done_raw = 1'b0;
        extOp    = 1'b0;
        aluSrc   = 1'b0;
        aluOp    = ALU_ADD;
        regDst   = 1'b0;
        memToReg = 1'b0;
        npcOp    = NPC_PC4;
        case (state)
            S_FETCH: begin
                pc_raw = 1'b1;
                ir_raw = 1'b1;
            end
            S_EXE_R: aluOp = (funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
            S_WB_R: begin
                reg_raw  = 1'b1;
                regDst   = 1'b1;
                done_raw = 1'b1;
            end
            S_EXE_I: begin
                aluSrc = 1'b1;
                aluOp  = ALU_OR;
                extOp  = ZERO;
            end
            S_WB_I: begin
                reg_raw  = 1'b1;
                extOp    = ZERO;
                done_raw = 1'b1;
            end
            S_MEM_ADR: begin
                aluSrc = 1'b1;
                extOp  = SIGN;
            end
            S_WB_LW: begin
                reg_raw  = 1'b1;
                memToReg = 1'b1;
                done_raw = 1'b1;
            end
            S_MEM_WR: begin
                mem_raw  = 1'b1;
                done_raw = 1'b1;
            end
            S_BRANCH: begin
                aluOp    = ALU_SUB;
                extOp    = SIGN;
                npcOp    = NPC_BR;
                pc_raw   = zero;    // only the taken branch updates PC
                done_raw = 1'b1;
            end
            S_JUMP: begin
                npcOp    = NPC_JMP;
                pc_raw   = 1'b1;
                done_raw = 1'b1;
            end
            default: ;
        endcase
    end

    assign pcWr      = pc_raw   & en;
    assign irWr      = ir_raw   & en;
    assign regWr     = reg_raw  & en;
    assign memWr     = mem_raw  & en;
    assign instrDone = done_raw & en;

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for a 7-instruction MIPS core
// (addu, subu, ori, lw, sw, beq, j).
// Ports: clk, rst_n (async, active low), en (advance enable), op/funct
// from IR, ALU zero flag in; datapath strobes and selects, instrDone,
// sticky illegal flag and retired-instruction counter out.
import mc_defs::*;

module mc_ctrl #(
    parameter int   CNT_W = 32,
    parameter logic ZERO  = 1'b0,
    parameter logic SIGN  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             pcWr,
    output logic             irWr,
    output logic             regWr,
    output logic             memWr,
    output logic             extOp,
    output logic             aluSrc,
    output logic [1:0]       aluOp,
    output logic             regDst,
    output logic             memToReg,
    output logic [1:0]       npcOp,
    output logic             instrDone,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_t state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_RST;
            retired <= '0;
            illegal <= 1'b0;
        end else if (en) begin
            // instrDone is already en-gated; counter wraps silently
            if (instrDone)
                retired <= retired + CNT_W'(1);
            case (state)
                S_RST:   state <= S_FETCH;
                S_FETCH: state <= S_DCD;
                S_DCD: begin
                    if (op == OP_RTYPE && (funct == FN_ADDU || funct == FN_SUBU))
                        state <= S_EXE_R;
                    else if (op == OP_ORI)
                        state <= S_EXE_I;
                    else if (op == OP_LW || op == OP_SW)
                        state <= S_MEM_ADR;
                    else if (op == OP_BEQ)
                        state <= S_BRANCH;
                    else if (op == OP_J)
                        state <= S_JUMP;
                    else begin
                        state   <= S_HALT;
                        illegal <= 1'b1;   // visible for the whole HALT stay
                    end
                end
                S_EXE_R:   state <= S_WB_R;
                S_WB_R:    state <= S_FETCH;
                S_EXE_I:   state <= S_WB_I;
                S_WB_I:    state <= S_FETCH;
                S_MEM_ADR: state <= (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
                S_MEM_RD:  state <= S_WB_LW;
                S_WB_LW:   state <= S_FETCH;
                S_MEM_WR:  state <= S_FETCH;
                S_BRANCH:  state <= S_FETCH;
                S_JUMP:    state <= S_FETCH;
                S_HALT: begin
                    state   <= S_HALT;
                    illegal <= 1'b1;
                end
                default:   state <= S_RST;   // unused encodings recover
            endcase
        end
    end

    mc_ctrl_out #(
        .ZERO (ZERO),
        .SIGN (SIGN)
    ) u_out (
        .state     (state),
        .funct     (funct),
        .zero      (zero),
        .en        (en),
        .pcWr      (pcWr),
        .irWr      (irWr),
        .regWr     (regWr),
        .memWr     (memWr),
        .extOp     (extOp),
        .aluSrc    (aluSrc),
        .aluOp     (aluOp),
        .regDst    (regDst),
        .memToReg  (memToReg),
        .npcOp     (npcOp),
        .instrDone (instrDone)
    );

endmodule
